// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS register file: default widths and the
// dump sequencer state encoding.
package mips_pkg;

  localparam int MIPS_DATA_W     = 32;
  localparam int MIPS_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BEAT = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_read_mux.sv
// One combinational register file read port with the hardwired-zero register
// rule and same-cycle write-through bypass.
module regfile_read_mux
  import mips_pkg::*;
#(
  parameter int DATA_W   = MIPS_DATA_W,
  parameter int ADDR_W   = MIPS_REG_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic zero_hit;

  assign zero_hit = (ZERO_REG != 0) && (raddr == '0);

  // Zero register wins over bypass, so a dropped write to r0 never leaks out.
  always_comb begin
    rdata = regs[raddr];
    if (zero_hit) begin
      rdata = '0;
    end else if (we && (waddr == raddr)) begin
      rdata = wdata;
    end
  end

endmodule

// File: rtl/mips_regfile_dump.sv
// Parametrised MIPS register file with NUM_RD read ports, a regNo/val debug
// tap and a ready/valid dump sequencer that streams every register out.
module mips_regfile_dump
  import mips_pkg::*;
#(
  parameter int DATA_W   = MIPS_DATA_W,
  parameter int ADDR_W   = MIPS_REG_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     startin_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0]        regNo,
  output logic [DATA_W-1:0]        val,
  input  logic                     dump_req,
  output logic                     dump_busy,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [ADDR_W-1:0]        dump_idx,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_done
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_en;
  logic [DATA_W-1:0] cap_data;
  logic [ADDR_W-1:0] idx;
  dump_state_t       state, state_next;

  // Writes are ignored while reset is asserted, so the bypass must be too.
  assign wr_en = we && startin_n;

  always_ff @(posedge clk) begin
    if (!startin_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && !((ZERO_REG != 0) && (waddr == '0))) begin
      regs[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_read_mux #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .regs (regs),
      .we   (wr_en),
      .waddr(waddr),
      .wdata(wdata),
      .raddr(raddr[k*ADDR_W +: ADDR_W]),
      .rdata(rdata[k*DATA_W +: DATA_W])
    );
  end

  regfile_read_mux #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_dbg (
    .regs (regs),
    .we   (wr_en),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(regNo),
    .rdata(val)
  );

  regfile_read_mux #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_cap (
    .regs (regs),
    .we   (wr_en),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(idx),
    .rdata(cap_data)
  );

  always_ff @(posedge clk) begin
    if (!startin_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dump_req) state_next = LOAD;
      LOAD:    state_next = BEAT;
      BEAT:    if (dump_ready) state_next = (idx == '1) ? DONE : LOAD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Beat contents are captured once in LOAD and held through any stall.
  always_ff @(posedge clk) begin
    if (!startin_n) begin
      idx       <= '0;
      dump_idx  <= '0;
      dump_data <= '0;
    end else begin
      if (state == IDLE && dump_req) begin
        idx <= '0;
      end else if (state == BEAT && dump_ready && idx != '1) begin
        idx <= idx + ADDR_W'(1);
      end
      if (state == LOAD) begin
        dump_idx  <= idx;
        dump_data <= cap_data;
      end
    end
  end

  assign dump_busy  = (state != IDLE);
  assign dump_valid = (state == BEAT);
  assign dump_done  = (state == DONE);

endmodule

// File: tb/tb_mips_regfile_dump.sv
// Directed bench for mips_regfile_dump: vector table for reads, zero register
// and bypass, plus hand sequences for dumps, backpressure and reset.
module tb_mips_regfile_dump;

  logic        clk = 1'b0;
  logic        startin_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [4:0]  regNo;
  logic [31:0] val;
  logic        dump_req;
  logic        dump_busy;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        dump_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mips_regfile_dump #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)
  ) dut (
    .clk(clk), .startin_n(startin_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .regNo(regNo), .val(val),
    .dump_req(dump_req), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_done(dump_done)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [4:0]  regno;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] ev;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic full_dump(input bit zeros);
    int beats, done_at, done_cnt;
    logic [31:0] e;
    beats = 0; done_at = -1; done_cnt = 0;
    dump_ready = 1'b1;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (dump_valid) begin
        e = zeros ? 32'h0 : beats * 32'h0101;
        check("full_idx", 32'(dump_idx), beats);
        check("full_data", dump_data, e);
        beats++;
      end
      if (dump_done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (done_at >= 0 && n > done_at + 2) break;
      step();
    end
    check("full_beats", beats, 32);
    check("full_done_cycle", done_at, 64);
    check("full_done_count", done_cnt, 1);
    check("full_busy_after", 32'(dump_busy), 0);
  endtask

  initial begin
    int beats, stall, found, late_done;
    bit collided;
    logic [31:0] e;

    startin_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    regNo = '0; dump_req = 1'b0; dump_ready = 1'b1;
    step(); step();
    startin_n = 1'b1;

    // Reset clears a written register
    write_reg(5'd9, 32'h1234);
    regNo = 5'd9; #1;
    check("pre_reset_val", val, 32'h1234);
    startin_n = 1'b0;
    step(); step();
    startin_n = 1'b1;
    raddr = {5'd9, 5'd9}; #1;
    check("reset_val", val, 32'h0);
    check("reset_rd0", rdata[31:0], 32'h0);
    check("reset_rd1", rdata[63:32], 32'h0);
    check("reset_valid", 32'(dump_valid), 0);
    check("reset_busy", 32'(dump_busy), 0);
    check("reset_dump_idx", 32'(dump_idx), 0);
    check("reset_dump_data", dump_data, 32'h0);

    vecs[0] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0,  32'h0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,         5'd0, 5'd0, 5'd0,  32'h0, 32'h0, 32'h0};
    vecs[2] = '{1'b1, 5'd9,  32'hDEAD_BEEF, 5'd5, 5'd9, 5'd9,  32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 5'd0,  32'h0,         5'd9, 5'd0, 5'd9,  32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 5'd5,  32'h5555,      5'd5, 5'd9, 5'd5,  32'h5555, 32'hDEAD_BEEF, 32'h5555};
    vecs[5] = '{1'b1, 5'd5,  32'h6666,      5'd5, 5'd5, 5'd9,  32'h6666, 32'h6666, 32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 5'd0,  32'h0,         5'd5, 5'd31, 5'd31, 32'h6666, 32'h0, 32'h0};
    vecs[7] = '{1'b1, 5'd31, 32'h1F1F,      5'd0, 5'd31, 5'd0,  32'h0, 32'h1F1F, 32'h0};

    for (int i = 0; i < 8; i++) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      raddr = {vecs[i].ra1, vecs[i].ra0}; regNo = vecs[i].regno;
      #1;
      check($sformatf("vec%0d_rd0", i), rdata[31:0], vecs[i].e0);
      check($sformatf("vec%0d_rd1", i), rdata[63:32], vecs[i].e1);
      check($sformatf("vec%0d_val", i), val, vecs[i].ev);
      step();
    end
    we = 1'b0;

    // Full dump with ready held high
    for (int i = 1; i < 32; i++) write_reg(5'(i), i * 32'h0101);
    full_dump(1'b0);

    // Backpressure on beat 3 with a stall-time write, and a LOAD collision on 7
    beats = 0; stall = 0; collided = 1'b0;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    for (int n = 0; n < 300; n++) begin
      we = 1'b0; dump_ready = 1'b1;
      if (dump_valid) begin
        if (dump_idx == 5'd3 && stall < 5) begin
          dump_ready = 1'b0;
          if (stall == 2) begin
            we = 1'b1; waddr = 5'd3; wdata = 32'hAAAA;
          end
          stall++;
        end
        e = (beats == 3) ? 32'h0303 : (beats == 7) ? 32'h7777 : beats * 32'h0101;
        check("bp_idx", 32'(dump_idx), beats);
        check("bp_data", dump_data, e);
        if (dump_ready) beats++;
      end else if (dump_busy && !dump_done && beats == 7 && !collided) begin
        we = 1'b1; waddr = 5'd7; wdata = 32'h7777;
        collided = 1'b1;
      end
      if (dump_done) break;
      step();
    end
    we = 1'b0; dump_ready = 1'b1;
    check("bp_beats", beats, 32);
    check("bp_stalls", stall, 5);
    raddr = {5'd7, 5'd3}; #1;
    check("bp_reg3_written", rdata[31:0], 32'hAAAA);
    check("bp_reg7_written", rdata[63:32], 32'h7777);
    step(); step();

    // Reset in the middle of a dump
    found = 0;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (dump_valid && dump_idx == 5'd10) begin
        found = 1;
        break;
      end
      step();
    end
    check("rst_mid_reached_10", found, 1);
    startin_n = 1'b0;
    step();
    check("rst_mid_busy", 32'(dump_busy), 0);
    check("rst_mid_valid", 32'(dump_valid), 0);
    check("rst_mid_done", 32'(dump_done), 0);
    startin_n = 1'b1;
    late_done = 0;
    for (int n = 0; n < 4; n++) begin
      if (dump_done || dump_busy) late_done++;
      step();
    end
    check("rst_mid_no_done", late_done, 0);
    full_dump(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
